// File: rtl/config_pkg.sv
// config_pkg: build-wide clock and debounce timing shared by the switch debouncer
package config_pkg;

   localparam int unsigned CLK_FREQ       = 100_000_000;
   localparam int unsigned STABLE_TIME_MS = 10;

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise a raw switch, require N stable cycles, emit level and rise tick
module switch_debouncer
   import config_pkg::*;
#(
   parameter int unsigned ClkFreq    = CLK_FREQ,
   parameter int unsigned StableTime = STABLE_TIME_MS
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic db_level_o,
   output logic db_tick_o
);

   localparam int unsigned N      = ClkFreq / 1000 * StableTime;
   localparam int unsigned CW     = (N < 2) ? 1 : $clog2(N);
   localparam logic [CW-1:0] CntMax = CW'(N - 1);

   if (N < 2) begin : g_bad_n
      $error("switch_debouncer: stability window N = %0d cycles, must be at least 2", N);
   end

   logic          ff1, ff2, ff3;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          tick_q, tick_d;

   // count cycles the synchronised input has held still; accept it once the counter is full
   always_comb begin
      cnt_d   = (ff2 != ff3) ? '0 : (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      level_d = (ff2 == ff3 && cnt_q == CntMax) ? ff3 : level_q;
      tick_d  = level_d & ~level_q;
   end

   // synchroniser chain plus counter and registered outputs, cleared by active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ff1     <= 1'b0;
         ff2     <= 1'b0;
         ff3     <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         ff1     <= sw_i;
         ff2     <= ff1;
         ff3     <= ff2;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         tick_q  <= tick_d;
      end
   end

   assign db_level_o = level_q;
   assign db_tick_o  = tick_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random switch patterns checked against a stability-window model
module tb_switch_debouncer;

   localparam int N = 10;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic sw_i = 1'b0;
   logic db_level_o, db_tick_o;

   int n_chk = 0, n_fail = 0, edge_no = 0, since = 0;
   int rise_at = -1, fall_at = -1, ticks = 0, mark = 0;
   bit hist[$];
   bit m_level = 1'b0, m_tick = 1'b0, prev_lvl = 1'b0;

   always #5 clk = ~clk;

   switch_debouncer #(.ClkFreq(10_000), .StableTime(1)) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .sw_i(sw_i),
      .db_level_o(db_level_o),
      .db_tick_o(db_tick_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", tag, $signed(got), $signed(exp), edge_no);
      end
   endtask

   // the synchronised input (sampled two edges back) must be identical over N+1 samples,
   // and the last N edges must all be out of reset
   function automatic bit stable_window();
      if (since < N) return 1'b0;
      for (int i = 3; i <= N + 3; i++)
         if (hist[hist.size() - i] != hist[hist.size() - 3]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic sw, input logic rst_n);
      sw_i  = sw;
      rst_i = rst_n;
      @(posedge clk);
      edge_no++;
      m_tick = 1'b0;
      if (!rst_n) begin
         hist    = {1'b0, 1'b0, 1'b0};
         since   = 0;
         m_level = 1'b0;
      end else begin
         hist.push_back(sw);
         since++;
         if (hist.size() > N + 6) void'(hist.pop_front());
         if (stable_window() && hist[hist.size() - 3] != m_level) begin
            m_level = hist[hist.size() - 3];
            m_tick  = m_level;
         end
      end
      #1;
      check("db_level", db_level_o, m_level);
      check("db_tick", db_tick_o, m_tick);
      if (db_level_o && !prev_lvl) rise_at = edge_no;
      if (!db_level_o && prev_lvl) fall_at = edge_no;
      ticks += int'(db_tick_o);
      prev_lvl = db_level_o;
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      hold(1'b0, 20);
      check("idle_level", db_level_o, 0);

      mark = edge_no; rise_at = -1; ticks = 0;
      hold(1'b1, 20);
      check("rise_latency", rise_at - mark, 13);
      check("rise_ticks", ticks, 1);

      mark = edge_no; fall_at = -1; ticks = 0;
      hold(1'b0, 20);
      check("fall_latency", fall_at - mark, 13);
      check("fall_ticks", ticks, 0);

      ticks = 0;
      hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
      mark = edge_no; rise_at = -1;
      hold(1'b1, 20);
      check("bounce_latency", rise_at - mark, 13);
      check("bounce_ticks", ticks, 1);

      hold(1'b0, 20);
      ticks = 0;
      hold(1'b1, 9);
      hold(1'b0, 20);
      check("glitch_ticks", ticks, 0);
      check("glitch_level", db_level_o, 0);

      hold(1'b1, 8);
      step(1'b1, 1'b0);
      check("rst_mid_level", db_level_o, 0);
      mark = edge_no; rise_at = -1; ticks = 0;
      hold(1'b1, 20);
      check("rst_rise_latency", rise_at - mark, 13);
      check("rst_rise_ticks", ticks, 1);

      for (int i = 0; i < 300; i++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) step(v, 1'b0);
         hold(v, $urandom_range(1, 2 * N + 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
